// File: rtl/minirisc_pkg.sv
// Shared opcodes, FSM states and opcode-beat field positions for the MiniRISC
// accumulator core.
package minirisc_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_LDI  = 4'h1,
        OP_ADDI = 4'h2,
        OP_SUBI = 4'h3,
        OP_STR  = 4'h4,
        OP_LDR  = 4'h5,
        OP_ADDR = 4'h6,
        OP_SUBR = 4'h7,
        OP_AND  = 4'h8,
        OP_OR   = 4'h9,
        OP_XOR  = 4'hA,
        OP_INC  = 4'hB,
        OP_DEC  = 4'hC,
        OP_CLR  = 4'hD
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_IMM  = 2'd1,
        ST_EXEC = 2'd2
    } state_t;

    localparam int OP_LSB  = 0;
    localparam int OP_W    = 4;
    localparam int REG_LSB = 4;

    function automatic logic is_imm_op(input op_t op);
        return (op == OP_LDI) || (op == OP_ADDI) || (op == OP_SUBI);
    endfunction

    function automatic logic is_legal_op(input logic [3:0] op);
        return op < 4'hE;
    endfunction

endpackage

// File: rtl/minirisc_alu.sv
// Combinational ALU for the MiniRISC core.
// Define MINIRISC_SAT_EN for saturating add/sub instead of modulo wrap.
module minirisc_alu
    import minirisc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_t              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero
);

    logic [WIDTH-1:0] bb;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;

    always_comb begin
        bb   = ((op == OP_INC) || (op == OP_DEC)) ? WIDTH'(1) : b;
        sum  = {1'b0, a} + {1'b0, bb};
        diff = {1'b0, a} - {1'b0, bb};
    end

    always_comb begin
        result = a;
        carry  = 1'b0;
        case (op)
            OP_LDI, OP_LDR: result = b;
            OP_ADDI, OP_ADDR, OP_INC: begin
                result = sum[WIDTH-1:0];
                carry  = sum[WIDTH];
`ifdef MINIRISC_SAT_EN
                if (sum[WIDTH]) result = '1;
`endif
            end
            OP_SUBI, OP_SUBR, OP_DEC: begin
                // diff[WIDTH] is set exactly when bb > a (unsigned borrow)
                result = diff[WIDTH-1:0];
                carry  = diff[WIDTH];
`ifdef MINIRISC_SAT_EN
                if (diff[WIDTH]) result = '0;
`endif
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_CLR:  result = '0;
            default: result = a;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/minirisc_acc_core.sv
// MiniRISC accumulator core: beat-stream FSM, accumulator, flags, register file.
// MINIRISC_SAT_EN (see minirisc_alu) selects saturating arithmetic.
module minirisc_acc_core
    import minirisc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREGS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] acc_out,
    output logic [1:0]       state_out,
    output logic             flag_c,
    output logic             flag_z,
    output logic             err
);

    localparam int RW = $clog2(NREGS);

    state_t           state_q, state_d;
    op_t              op_q, op_d;
    logic [RW-1:0]    r_q, r_d;
    logic [WIDTH-1:0] imm_q, imm_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             c_q, c_d;
    logic             z_q, z_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];

    logic             xfer;
    logic [3:0]       op_raw;
    op_t              op_in;
    logic [RW-1:0]    r_in;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_z;

    assign in_ready = ena && ((state_q == ST_IDLE) || (state_q == ST_IMM));
    assign xfer     = in_valid && in_ready;
    assign op_raw   = in_data[OP_LSB +: OP_W];
    assign op_in    = op_t'(op_raw);
    assign r_in     = in_data[REG_LSB +: RW];
    assign alu_b    = is_imm_op(op_q) ? imm_q : regs_q[r_q];

    minirisc_alu #(.WIDTH(WIDTH)) u_alu (
        .op     (op_q),
        .a      (acc_q),
        .b      (alu_b),
        .result (alu_res),
        .carry  (alu_c),
        .zero   (alu_z)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        r_d     = r_q;
        imm_d   = imm_q;
        acc_d   = acc_q;
        c_d     = c_q;
        z_d     = z_q;
        err_d   = 1'b0;
        regs_d  = regs_q;
        if (!ena) begin
            state_d = ST_IDLE;
            acc_d   = '0;
            c_d     = 1'b0;
            z_d     = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (xfer) begin
                        unique case (1'b1)
                            !is_legal_op(op_raw): err_d = 1'b1;
                            (op_in == OP_NOP): state_d = ST_IDLE;
                            is_imm_op(op_in): begin
                                op_d    = op_in;
                                state_d = ST_IMM;
                            end
                            default: begin
                                op_d    = op_in;
                                r_d     = r_in;
                                state_d = ST_EXEC;
                            end
                        endcase
                    end
                end
                ST_IMM: begin
                    if (xfer) begin
                        imm_d   = in_data;
                        state_d = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    state_d = ST_IDLE;
                    if (op_q == OP_STR) begin
                        regs_d[r_q] = acc_q;
                    end else begin
                        acc_d = alu_res;
                        c_d   = alu_c;
                        z_d   = alu_z;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_NOP;
            r_q     <= '0;
            imm_q   <= '0;
            acc_q   <= '0;
            c_q     <= 1'b0;
            z_q     <= 1'b1;
            err_q   <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            r_q     <= r_d;
            imm_q   <= imm_d;
            acc_q   <= acc_d;
            c_q     <= c_d;
            z_q     <= z_d;
            err_q   <= err_d;
            regs_q  <= regs_d;
        end
    end

    assign acc_out   = acc_q;
    assign state_out = state_q;
    assign flag_c    = c_q;
    assign flag_z    = z_q;
    assign err       = err_q;

endmodule
